// File: rtl/gray_chk_pkg.sv
// Shared FSM state type and gray/step helper functions for the gray sequence checker.
package gray_chk_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray, input int width);
    logic [MAX_W-1:0] bin;
    logic             acc;
    bin = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

  // A step is legal when it moves exactly one position forward (or backward when bidir is set).
  function automatic logic next_legal(input logic [MAX_W-1:0] prev,
                                      input logic [MAX_W-1:0] nxt,
                                      input int               width,
                                      input logic             bidir);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] up;
    logic [MAX_W-1:0] dn;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    up   = (prev + MAX_W'(1)) & mask;
    dn   = (prev - MAX_W'(1)) & mask;
    return (nxt == up) || (bidir && (nxt == dn));
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module gray_to_bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_seq_checker.sv
// Gray sequence checker: converts sampled gray codes to binary and tracks step legality and health.
// Define GRAY_CHK_BIDIR_EN to also accept single backward steps from up/down counters.
module gray_seq_checker
  import gray_chk_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int RELOCK = 4,
  parameter int ECNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [WIDTH-1:0]  gray_in_i,
  input  logic              clr_err_i,
  output logic [WIDTH-1:0]  bin_out_o,
  output logic              bin_valid_o,
  output logic              wrap_o,
  output logic              step_err_o,
  output logic              fault_o,
  output logic [ECNT_W-1:0] err_cnt_o
);

`ifdef GRAY_CHK_BIDIR_EN
  localparam logic BIDIR = 1'b1;
`else
  localparam logic BIDIR = 1'b0;
`endif

  localparam int GOOD_W = $clog2(RELOCK + 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic                stepErr_q, stepErr_d;
  logic [ECNT_W-1:0]   errCnt_q, errCnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;

  logic [WIDTH-1:0]    binNew;
  logic                stepLegal;
  logic                isWrap;

  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_gray_to_bin (
    .gray_i(gray_in_i),
    .bin_o (binNew)
  );

  assign stepLegal = next_legal(MAX_W'(bin_q), MAX_W'(binNew), WIDTH, BIDIR);
  assign isWrap    = ((bin_q == '1) && (binNew == '0)) ||
                     (BIDIR && (bin_q == '0) && (binNew == '1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      stepErr_q <= 1'b0;
      errCnt_q  <= '0;
      good_q    <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      stepErr_q <= stepErr_d;
      errCnt_q  <= errCnt_d;
      good_q    <= good_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    stepErr_d = 1'b0;
    errCnt_d  = errCnt_q;
    good_d    = good_q;

    // Clearing wins over sampling: the code is still captured but never checked.
    if (clr_err_i) begin
      errCnt_d = '0;
      good_d   = '0;
      valid_d  = 1'b0;
      state_d  = IDLE;
      if (en_i) bin_d = binNew;
    end else if (en_i) begin
      bin_d = binNew;
      unique case (state_q)
        IDLE: begin
          valid_d = 1'b1;
          good_d  = '0;
          state_d = TRACK;
        end
        TRACK: begin
          if (stepLegal) begin
            wrap_d = isWrap;
          end else begin
            stepErr_d = 1'b1;
            if (errCnt_q != '1) errCnt_d = errCnt_q + 1'b1;
            good_d  = '0;
            state_d = FAULT;
          end
        end
        FAULT: begin
          if (stepLegal) begin
            wrap_d = isWrap;
            if (good_q == GOOD_W'(RELOCK - 1)) begin
              good_d  = '0;
              state_d = TRACK;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            stepErr_d = 1'b1;
            if (errCnt_q != '1) errCnt_d = errCnt_q + 1'b1;
            good_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bin_out_o   = bin_q;
  assign bin_valid_o = valid_q;
  assign wrap_o      = wrap_q;
  assign step_err_o  = stepErr_q;
  assign fault_o     = (state_q == FAULT);
  assign err_cnt_o   = errCnt_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed bench for gray_seq_checker; a second instance with a 2-bit error counter covers saturation.
module tb_gray_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] grayIn;
  logic       clrErr;

  logic [2:0] binOut;
  logic       binValid;
  logic       wrap;
  logic       stepErr;
  logic       fault;
  logic [7:0] errCnt;

  logic [2:0] binOut2;
  logic       binValid2;
  logic       wrap2;
  logic       stepErr2;
  logic       fault2;
  logic [1:0] errCnt2;

  int checks   = 0;
  int failures = 0;

`ifdef GRAY_CHK_BIDIR_EN
  localparam int BIDIR = 1;
`else
  localparam int BIDIR = 0;
`endif

  gray_seq_checker #(.WIDTH(3), .RELOCK(4), .ECNT_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .gray_in_i  (grayIn),
    .clr_err_i  (clrErr),
    .bin_out_o  (binOut),
    .bin_valid_o(binValid),
    .wrap_o     (wrap),
    .step_err_o (stepErr),
    .fault_o    (fault),
    .err_cnt_o  (errCnt)
  );

  gray_seq_checker #(.WIDTH(3), .RELOCK(4), .ECNT_W(2)) dutSat (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .gray_in_i  (grayIn),
    .clr_err_i  (clrErr),
    .bin_out_o  (binOut2),
    .bin_valid_o(binValid2),
    .wrap_o     (wrap2),
    .step_err_o (stepErr2),
    .fault_o    (fault2),
    .err_cnt_o  (errCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic rstV, input logic enV, input logic clrV,
                               input logic [2:0] grayV);
    @(negedge clk);
    rst    = rstV;
    en     = enV;
    clrErr = clrV;
    grayIn = grayV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_bin"},   int'(binOut),   0);
    checkOutput({tag, "_valid"}, int'(binValid), 0);
    checkOutput({tag, "_wrap"},  int'(wrap),     0);
    checkOutput({tag, "_serr"},  int'(stepErr),  0);
    checkOutput({tag, "_fault"}, int'(fault),    0);
    checkOutput({tag, "_ecnt"},  int'(errCnt),   0);
  endtask

  logic [2:0] grayTab [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                              3'b111, 3'b101, 3'b100, 3'b000};
  int         binTab  [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int         satTab  [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    clrErr = 1'b0;
    grayIn = 3'b000;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    checkAllReset("reset");

    // Full forward sequence with one wrap
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, grayTab[i]);
      checkOutput($sformatf("seq_bin%0d", i),  int'(binOut),  binTab[i]);
      checkOutput($sformatf("seq_wrap%0d", i), int'(wrap),    (i == 8) ? 1 : 0);
      checkOutput($sformatf("seq_serr%0d", i), int'(stepErr), 0);
    end
    checkOutput("seq_valid", int'(binValid), 1);
    checkOutput("seq_fault", int'(fault),    0);
    checkOutput("seq_ecnt",  int'(errCnt),   0);

    // en low holds position and clears pulses
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b111);
    checkOutput("hold_bin",  int'(binOut), 0);
    checkOutput("hold_wrap", int'(wrap),   0);

    // Illegal jump 1 -> 3
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b001);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010);
    checkOutput("jump_serr",  int'(stepErr), 1);
    checkOutput("jump_fault", int'(fault),   1);
    checkOutput("jump_ecnt",  int'(errCnt),  1);
    checkOutput("jump_bin",   int'(binOut),  3);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b010);
    checkOutput("jump_serr_pulse", int'(stepErr), 0);
    checkOutput("jump_fault_hold", int'(fault),   1);

    // Two legal steps, then a repeat restarts the relock count
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b110);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b111);
    checkOutput("relock_partial_fault", int'(fault), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b111);
    checkOutput("repeat_serr", int'(stepErr), 1);
    checkOutput("repeat_ecnt", int'(errCnt),  2);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b101);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b100);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    checkOutput("fault_wrap",    int'(wrap),  1);
    checkOutput("relock3_fault", int'(fault), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b001);
    checkOutput("relock4_fault", int'(fault),   0);
    checkOutput("relock4_bin",   int'(binOut),  1);
    checkOutput("relock4_ecnt",  int'(errCnt),  2);

    // Reverse step 2 -> 1
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b011);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b001);
    checkOutput("rev_serr", int'(stepErr), (BIDIR != 0) ? 0 : 1);
    checkOutput("rev_ecnt", int'(errCnt),  (BIDIR != 0) ? 0 : 1);
    checkOutput("rev_bin",  int'(binOut),  1);

    // Reverse wrap 0 -> 7
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b100);
    checkOutput("revwrap_wrap", int'(wrap),    (BIDIR != 0) ? 1 : 0);
    checkOutput("revwrap_serr", int'(stepErr), (BIDIR != 0) ? 0 : 1);

    // Error counter saturation on the 2-bit instance
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
      checkOutput($sformatf("sat_ecnt%0d", i), int'(errCnt2), satTab[i]);
    end
    checkOutput("sat_wide_ecnt", int'(errCnt), 5);

    // clr_err beats an illegal sample
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b001);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b111);
    checkOutput("pre_clr_ecnt", int'(errCnt), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
    checkOutput("clr_serr",  int'(stepErr),  0);
    checkOutput("clr_ecnt",  int'(errCnt),   0);
    checkOutput("clr_valid", int'(binValid), 0);
    checkOutput("clr_fault", int'(fault),    0);
    checkOutput("clr_bin",   int'(binOut),   0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b111);
    checkOutput("idle_capture_serr",  int'(stepErr),  0);
    checkOutput("idle_capture_valid", int'(binValid), 1);
    checkOutput("idle_capture_bin",   int'(binOut),   5);

    // Reset in the middle of FAULT
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    checkOutput("midfault_fault", int'(fault), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b001);
    checkAllReset("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
